multicore_cpu_3_cpu_mul_result_assembler: RTL and testbench

//  Consumer end of the 4-way 16x16 multiplier cell. Takes the four M-stage partial products (p1..p4) and
//  the operand signedness flags, and reduces them to the 64-bit product over two enabled pipeline stages
//  (M->A, A->W). Presents the selected 32-bit half, its valid bit and destination tag at W for writeback
//  and bypass.

---
 rtl/cpu_mul_pkg.sv | 26 ++
 rtl/multicore_cpu_3_cpu_mul_pp_ext.sv | 35 +++
 rtl/multicore_cpu_3_cpu_mul_result_assembler.sv | 143 ++++++++++++++
 tb/tb_multicore_cpu_3_cpu_mul_result_assembler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mul_pkg.sv
// Shared definitions for the multiplier result path: widths, the mul control
// bundle that rides alongside the partial products, and the 64-bit extender.
package cpu_mul_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned PP_W     = 16;
  localparam int unsigned TAG_W    = 5;
  localparam int unsigned PROD_W   = 64;
  // Low partial sum: three 32-bit terms need two carry bits.
  localparam int unsigned LO_SUM_W = DATA_W + 2;

  typedef struct packed {
    logic             hi;
    logic             src1_signed;
    logic             src2_signed;
    logic [TAG_W-1:0] tag;
    logic             valid;
  } mul_ctrl_t;

  // Extend a 32-bit partial product to 64 bits, sign or zero.
  function automatic logic [PROD_W-1:0] sext64(input logic [DATA_W-1:0] v,
                                               input logic              is_signed);
    sext64 = {{(PROD_W - DATA_W){is_signed & v[DATA_W-1]}}, v};
  endfunction

endpackage

// File: rtl/multicore_cpu_3_cpu_mul_pp_ext.sv
// Combinational sign extension of the cross partial products and the A-stage sums.
//   p1..p3       : lo*lo, lo*hi2, hi1*lo partial products
//   src1/2_signed: operand signedness, aligned with p1..p3
//   lo34_c       : p1 + p2[15:0]<<16 + p3[15:0]<<16, with carries
//   mid_c        : (ext(p2)>>16) + (ext(p3)>>16), low 32 bits
// p4 needs no work here: its extension lands entirely above bit 63.
module multicore_cpu_3_cpu_mul_pp_ext
  import cpu_mul_pkg::*;
(
  input  logic [DATA_W-1:0]   p1,
  input  logic [DATA_W-1:0]   p2,
  input  logic [DATA_W-1:0]   p3,
  input  logic                src1_signed,
  input  logic                src2_signed,
  output logic [LO_SUM_W-1:0] lo34_c,
  output logic [DATA_W-1:0]   mid_c
);

  logic [PROD_W-1:0] p2x;
  logic [PROD_W-1:0] p3x;
  logic              unused_ext_top_c;

  assign p2x = sext64(p2, src2_signed);
  assign p3x = sext64(p3, src1_signed);

  assign lo34_c = LO_SUM_W'(p1)
                + LO_SUM_W'({p2[PP_W-1:0], PP_W'(0)})
                + LO_SUM_W'({p3[PP_W-1:0], PP_W'(0)});

  // Only bits [47:16] of the extended terms can reach product[63:32].
  assign mid_c = p2x[DATA_W+PP_W-1:PP_W] + p3x[DATA_W+PP_W-1:PP_W];

  assign unused_ext_top_c = ^{p2x[PROD_W-1:DATA_W+PP_W], p3x[PROD_W-1:DATA_W+PP_W]};

endmodule

// File: rtl/multicore_cpu_3_cpu_mul_result_assembler.sv
// Reduces the four 16x16 partial products to a 64-bit product over two
// enabled stages (M->A, A->W) and presents the selected half at W.
//   clk, reset_n        : core clock, async active-low reset
//   M_en / A_en         : stage advance enables
//   M_*                 : mul valid, hi select, signedness, tag, p1..p4
//   A_mul_busy          : live multiply sitting in A
//   W_mul_valid/dst_tag : writeback qualifier and destination
//   W_mul_result        : selected 32-bit half; W_mul_product full product
module multicore_cpu_3_cpu_mul_result_assembler #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                M_en,
  input  logic                A_en,
  input  logic                M_mul_valid,
  input  logic                M_ctrl_mul_hi,
  input  logic                M_ctrl_mul_src1_signed,
  input  logic                M_ctrl_mul_src2_signed,
  input  logic [TAG_W-1:0]    M_dst_tag,
  input  logic [DATA_W-1:0]   M_mul_cell_p1,
  input  logic [DATA_W-1:0]   M_mul_cell_p2,
  input  logic [DATA_W-1:0]   M_mul_cell_p3,
  input  logic [DATA_W-1:0]   M_mul_cell_p4,
  output logic                A_mul_busy,
  output logic                W_mul_valid,
  output logic [TAG_W-1:0]    W_mul_dst_tag,
  output logic [DATA_W-1:0]   W_mul_result,
  output logic [2*DATA_W-1:0] W_mul_product
);

  localparam int unsigned LO_SUM_W   = cpu_mul_pkg::LO_SUM_W;
  localparam int unsigned CTRL_TAG_W = cpu_mul_pkg::TAG_W;

  cpu_mul_pkg::mul_ctrl_t m_ctrl_c;

  logic [LO_SUM_W-1:0] lo34_c;
  logic [DATA_W-1:0]   mid_c;

  logic                a_valid_q,  a_valid_d;
  logic                a_hi_q,     a_hi_d;
  logic [TAG_W-1:0]    a_tag_q,    a_tag_d;
  logic [LO_SUM_W-1:0] a_lo34_q,   a_lo34_d;
  logic [DATA_W-1:0]   a_mid_q,    a_mid_d;
  logic [DATA_W-1:0]   a_p4_q,     a_p4_d;

  logic                w_valid_q,   w_valid_d;
  logic [TAG_W-1:0]    w_tag_q,     w_tag_d;
  logic [DATA_W-1:0]   w_result_q,  w_result_d;
  logic [2*DATA_W-1:0] w_product_q, w_product_d;

  logic [DATA_W-1:0]   w_lo_c;
  logic [DATA_W-1:0]   w_hi_c;

  // M-stage control bundle.
  always_comb begin
    m_ctrl_c             = '0;
    m_ctrl_c.hi          = M_ctrl_mul_hi;
    m_ctrl_c.src1_signed = M_ctrl_mul_src1_signed;
    m_ctrl_c.src2_signed = M_ctrl_mul_src2_signed;
    m_ctrl_c.tag         = CTRL_TAG_W'(M_dst_tag);
    m_ctrl_c.valid       = M_mul_valid;
  end

  multicore_cpu_3_cpu_mul_pp_ext u_pp_ext (
    .p1          (M_mul_cell_p1),
    .p2          (M_mul_cell_p2),
    .p3          (M_mul_cell_p3),
    .src1_signed (m_ctrl_c.src1_signed),
    .src2_signed (m_ctrl_c.src2_signed),
    .lo34_c      (lo34_c),
    .mid_c       (mid_c)
  );

  // Final carry-propagate: upper half collects p4, mid sum and low-sum carries.
  assign w_lo_c = a_lo34_q[DATA_W-1:0];
  assign w_hi_c = a_p4_q + a_mid_q + DATA_W'(a_lo34_q[LO_SUM_W-1:DATA_W]);

  // Next state for both stages; a low enable holds the stage.
  always_comb begin
    a_valid_d   = a_valid_q;
    a_hi_d      = a_hi_q;
    a_tag_d     = a_tag_q;
    a_lo34_d    = a_lo34_q;
    a_mid_d     = a_mid_q;
    a_p4_d      = a_p4_q;
    w_valid_d   = w_valid_q;
    w_tag_d     = w_tag_q;
    w_result_d  = w_result_q;
    w_product_d = w_product_q;

    if (M_en) begin
      a_valid_d = m_ctrl_c.valid;
      a_hi_d    = m_ctrl_c.hi;
      a_tag_d   = TAG_W'(m_ctrl_c.tag);
      a_lo34_d  = lo34_c;
      a_mid_d   = mid_c;
      a_p4_d    = M_mul_cell_p4;
    end

    if (A_en) begin
      w_valid_d   = a_valid_q;
      w_tag_d     = a_tag_q;
      w_result_d  = a_hi_q ? w_hi_c : w_lo_c;
      w_product_d = {w_hi_c, w_lo_c};
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_valid_q   <= 1'b0;
      a_hi_q      <= 1'b0;
      a_tag_q     <= '0;
      a_lo34_q    <= '0;
      a_mid_q     <= '0;
      a_p4_q      <= '0;
      w_valid_q   <= 1'b0;
      w_tag_q     <= '0;
      w_result_q  <= '0;
      w_product_q <= '0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_hi_q      <= a_hi_d;
      a_tag_q     <= a_tag_d;
      a_lo34_q    <= a_lo34_d;
      a_mid_q     <= a_mid_d;
      a_p4_q      <= a_p4_d;
      w_valid_q   <= w_valid_d;
      w_tag_q     <= w_tag_d;
      w_result_q  <= w_result_d;
      w_product_q <= w_product_d;
    end
  end

  assign A_mul_busy    = a_valid_q;
  assign W_mul_valid   = w_valid_q;
  assign W_mul_dst_tag = w_tag_q;
  assign W_mul_result  = w_result_q;
  assign W_mul_product = w_product_q;

endmodule

// File: tb/tb_multicore_cpu_3_cpu_mul_result_assembler.sv
// Bench for the multiply result assembler: feeds partial products built from
// real operands, checks W against a 64-bit golden product every cycle.
module tb_multicore_cpu_3_cpu_mul_result_assembler;

  logic        clk;
  logic        reset_n;
  logic        M_en;
  logic        A_en;
  logic        M_mul_valid;
  logic        M_ctrl_mul_hi;
  logic        M_ctrl_mul_src1_signed;
  logic        M_ctrl_mul_src2_signed;
  logic [4:0]  M_dst_tag;
  logic [31:0] M_mul_cell_p1;
  logic [31:0] M_mul_cell_p2;
  logic [31:0] M_mul_cell_p3;
  logic [31:0] M_mul_cell_p4;
  logic        A_mul_busy;
  logic        W_mul_valid;
  logic [4:0]  W_mul_dst_tag;
  logic [31:0] W_mul_result;
  logic [63:0] W_mul_product;

  logic [31:0] op_a;
  logic [31:0] op_b;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        valid;
    logic        hi;
    logic [4:0]  tag;
    logic [63:0] prod;
  } op_t;

  op_t mdl_a;
  op_t mdl_w;

  multicore_cpu_3_cpu_mul_result_assembler #(.DATA_W(32), .TAG_W(5)) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .M_en                   (M_en),
    .A_en                   (A_en),
    .M_mul_valid            (M_mul_valid),
    .M_ctrl_mul_hi          (M_ctrl_mul_hi),
    .M_ctrl_mul_src1_signed (M_ctrl_mul_src1_signed),
    .M_ctrl_mul_src2_signed (M_ctrl_mul_src2_signed),
    .M_dst_tag              (M_dst_tag),
    .M_mul_cell_p1          (M_mul_cell_p1),
    .M_mul_cell_p2          (M_mul_cell_p2),
    .M_mul_cell_p3          (M_mul_cell_p3),
    .M_mul_cell_p4          (M_mul_cell_p4),
    .A_mul_busy             (A_mul_busy),
    .W_mul_valid            (W_mul_valid),
    .W_mul_dst_tag          (W_mul_dst_tag),
    .W_mul_result           (W_mul_result),
    .W_mul_product          (W_mul_product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 16x16 multiplier cell: each half signed or unsigned, product kept to 32 bits.
  function automatic logic [31:0] pp(input logic [15:0] x, input logic xs,
                                     input logic [15:0] y, input logic ys);
    longint xv;
    longint yv;
    xv = xs ? longint'($signed(x)) : longint'(x);
    yv = ys ? longint'($signed(y)) : longint'(y);
    return 32'(xv * yv);
  endfunction

  // Full-width reference product.
  function automatic logic [63:0] golden(input logic [31:0] a, input logic [31:0] b,
                                         input logic sa, input logic sb);
    logic [63:0] ax;
    logic [63:0] bx;
    ax = sa ? {{32{a[31]}}, a} : {32'd0, a};
    bx = sb ? {{32{b[31]}}, b} : {32'd0, b};
    return ax * bx;
  endfunction

  assign M_mul_cell_p1 = pp(op_a[15:0],  1'b0,                   op_b[15:0],  1'b0);
  assign M_mul_cell_p2 = pp(op_a[15:0],  1'b0,                   op_b[31:16], M_ctrl_mul_src2_signed);
  assign M_mul_cell_p3 = pp(op_a[31:16], M_ctrl_mul_src1_signed, op_b[15:0],  1'b0);
  assign M_mul_cell_p4 = pp(op_a[31:16], M_ctrl_mul_src1_signed, op_b[31:16], M_ctrl_mul_src2_signed);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Transaction-level model: an op enters A on an M_en edge, moves to W on an A_en edge.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mdl_a <= '{valid: 1'b0, hi: 1'b0, tag: 5'd0, prod: 64'd0};
      mdl_w <= '{valid: 1'b0, hi: 1'b0, tag: 5'd0, prod: 64'd0};
    end else begin
      if (A_en) mdl_w <= mdl_a;
      if (M_en) mdl_a <= '{valid: M_mul_valid, hi: M_ctrl_mul_hi, tag: M_dst_tag,
                           prod: golden(op_a, op_b, M_ctrl_mul_src1_signed,
                                        M_ctrl_mul_src2_signed)};
    end
  end

  always @(posedge clk) begin
    if (reset_n) assert (!(M_en && !A_en)) else $error("illegal stall: M_en high with A_en low");
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [31:0] exp_half;
    chk("busy", 64'(A_mul_busy), 64'(mdl_a.valid));
    chk("w_valid", 64'(W_mul_valid), 64'(mdl_w.valid));
    if (mdl_w.valid) begin
      exp_half = mdl_w.hi ? mdl_w.prod[63:32] : mdl_w.prod[31:0];
      chk("w_tag", 64'(W_mul_dst_tag), 64'(mdl_w.tag));
      chk("w_result", 64'(W_mul_result), 64'(exp_half));
      chk("w_product", W_mul_product, mdl_w.prod);
    end
  end

  task automatic drive(input logic m_en, input logic a_en, input logic v,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic s1, input logic s2, input logic hi,
                       input logic [4:0] tag);
    @(posedge clk);
    #2;
    M_en                   = m_en;
    A_en                   = a_en;
    M_mul_valid            = v;
    op_a                   = a;
    op_b                   = b;
    M_ctrl_mul_src1_signed = s1;
    M_ctrl_mul_src2_signed = s2;
    M_ctrl_mul_hi          = hi;
    M_dst_tag              = tag;
  endtask

  task automatic bubble();
    drive(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  initial begin
    reset_n                = 1'b1;
    M_en                   = 1'b0;
    A_en                   = 1'b0;
    M_mul_valid            = 1'b0;
    M_ctrl_mul_hi          = 1'b0;
    M_ctrl_mul_src1_signed = 1'b0;
    M_ctrl_mul_src2_signed = 1'b0;
    M_dst_tag              = 5'd0;
    op_a                   = 32'd0;
    op_b                   = 32'd0;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state and model pins.
    chk("rst_valid",   64'(W_mul_valid),   64'd0);
    chk("rst_busy",    64'(A_mul_busy),    64'd0);
    chk("rst_product", W_mul_product,      64'd0);
    chk("gold_uu", golden(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0), 64'hFFFFFFFE_00000001);
    chk("gold_su", golden(32'hFFFFFFFE, 32'h00000003, 1'b1, 1'b0), 64'hFFFFFFFF_FFFFFFFA);
    @(posedge clk);
    #2 reset_n = 1'b1;

    // 1. unsigned all-ones squared, low then high half.
    drive(1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 5'd1);
    drive(1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 5'd2);
    bubble();
    @(negedge clk);
    chk("t1_lo",   64'(W_mul_result), 64'h00000001);
    chk("t1_prod", W_mul_product,     64'hFFFFFFFE_00000001);
    bubble();
    @(negedge clk);
    chk("t1_hi",   64'(W_mul_result), 64'hFFFFFFFE);

    // 2. signed*signed.
    drive(1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 5'd4);
    drive(1'b1, 1'b1, 1'b1, 32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b1, 5'd5);
    bubble();
    @(negedge clk);
    chk("t2_ss_prod", W_mul_product, 64'h00000000_00000001);
    bubble();
    @(negedge clk);
    chk("t2_min_hi",   64'(W_mul_result), 64'h40000000);
    chk("t2_min_prod", W_mul_product,     64'h40000000_00000000);

    // 3. signed*unsigned.
    drive(1'b1, 1'b1, 1'b1, 32'hFFFFFFFE, 32'h00000003, 1'b1, 1'b0, 1'b1, 5'd6);
    drive(1'b1, 1'b1, 1'b1, 32'hFFFFFFFE, 32'h00000003, 1'b1, 1'b0, 1'b0, 5'd7);
    bubble();
    @(negedge clk);
    chk("t3_su_hi", 64'(W_mul_result), 64'hFFFFFFFF);
    bubble();
    @(negedge clk);
    chk("t3_su_lo", 64'(W_mul_result), 64'hFFFFFFFA);

    // 4. three back-to-back multiplies then a bubble.
    drive(1'b1, 1'b1, 1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 1'b0, 5'd3);
    drive(1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 32'h00010001, 1'b1, 1'b1, 1'b1, 5'd7);
    drive(1'b1, 1'b1, 1'b1, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 5'd12);
    @(negedge clk);
    chk("t4_tag0", 64'(W_mul_dst_tag), 64'd3);
    bubble();
    @(negedge clk);
    chk("t4_tag1", 64'(W_mul_dst_tag), 64'd7);
    bubble();
    @(negedge clk);
    chk("t4_tag2",  64'(W_mul_dst_tag), 64'd12);
    chk("t4_res2",  64'(W_mul_result),  64'h80000001);
    chk("t4_prod2", W_mul_product,      64'h7FFFFFFE_80000001);
    bubble();
    @(negedge clk);
    chk("t4_drain", 64'(W_mul_valid), 64'd0);

    // 5. full stall with a multiply held in A.
    drive(1'b1, 1'b1, 1'b1, 32'h00010000, 32'h00010000, 1'b0, 1'b0, 1'b1, 5'd9);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
      @(negedge clk);
      chk("t5_busy_held",  64'(A_mul_busy),  64'd1);
      chk("t5_w_held",     64'(W_mul_valid), 64'd0);
    end
    bubble();
    @(negedge clk);
    chk("t5_pre_release", 64'(W_mul_valid), 64'd0);
    bubble();
    @(negedge clk);
    chk("t5_valid", 64'(W_mul_valid),   64'd1);
    chk("t5_tag",   64'(W_mul_dst_tag), 64'd9);
    chk("t5_res",   64'(W_mul_result),  64'h00000001);

    // 6. reset with live multiplies in A and W.
    drive(1'b1, 1'b1, 1'b1, 32'hFFFF0000, 32'h00000010, 1'b1, 1'b1, 1'b0, 5'd1);
    drive(1'b1, 1'b1, 1'b1, 32'h00000003, 32'h00000005, 1'b0, 1'b0, 1'b0, 5'd2);
    bubble();
    chk("t6_pre_busy",  64'(A_mul_busy),  64'd1);
    chk("t6_pre_valid", 64'(W_mul_valid), 64'd1);
    chk("t6_pre_prod",  W_mul_product,    64'hFFFFFFFF_FFF00000);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_rst_valid",  64'(W_mul_valid),   64'd0);
    chk("t6_rst_busy",   64'(A_mul_busy),    64'd0);
    chk("t6_rst_tag",    64'(W_mul_dst_tag), 64'd0);
    chk("t6_rst_result", 64'(W_mul_result),  64'd0);
    chk("t6_rst_prod",   W_mul_product,      64'd0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 32'h00000007, 32'h00000006, 1'b0, 1'b0, 1'b0, 5'd13);
    bubble();
    bubble();
    @(negedge clk);
    chk("t6_after_valid", 64'(W_mul_valid),   64'd1);
    chk("t6_after_tag",   64'(W_mul_dst_tag), 64'd13);
    chk("t6_after_res",   64'(W_mul_result),  64'd42);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
